pixel_sequencer: RTL and testbench



---
 rtl/pixel_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_pixel_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_sequencer
// Description : Per-pixel sequencer between the UART receiver, the colour
//               transform core and the UART transmitter. Assembles R/G/B
//               bytes into a pixel, launches the core with the latched mode,
//               returns the three result bytes to the transmitter, counts
//               pixels per frame and reports rx errors, timeouts and drops.
//               Optional inter-byte timeout: define PIXSEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_sequencer #(
    parameter int PIX_CNT_W   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 data_ready,
    input  logic                 rx_error,
    input  logic [1:0]           mode,
    input  logic [PIX_CNT_W-1:0] frame_len,
    input  logic                 core_done,
    input  logic [7:0]           core_r,
    input  logic [7:0]           core_g,
    input  logic [7:0]           core_b,
    input  logic                 tx_busy,
    output logic [7:0]           pix_r,
    output logic [7:0]           pix_g,
    output logic [7:0]           pix_b,
    output logic [1:0]           core_mode,
    output logic                 core_start,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    output logic [PIX_CNT_W-1:0] pixel_count,
    output logic                 frame_done,
    output logic                 err,
    output logic [1:0]           err_code
);

    // Sequencer states; each TX state is followed by a one-cycle guard state
    // covering the gap before the transmitter raises tx_busy.
    localparam logic [3:0] c_ST_IDLE      = 4'd0;
    localparam logic [3:0] c_ST_GET_G     = 4'd1;
    localparam logic [3:0] c_ST_GET_B     = 4'd2;
    localparam logic [3:0] c_ST_START     = 4'd3;
    localparam logic [3:0] c_ST_WAIT_CORE = 4'd4;
    localparam logic [3:0] c_ST_TX_R      = 4'd5;
    localparam logic [3:0] c_ST_TX_R_GRD  = 4'd6;
    localparam logic [3:0] c_ST_TX_G      = 4'd7;
    localparam logic [3:0] c_ST_TX_G_GRD  = 4'd8;
    localparam logic [3:0] c_ST_TX_B      = 4'd9;
    localparam logic [3:0] c_ST_TX_B_GRD  = 4'd10;

    localparam logic [1:0] c_ERR_RX      = 2'd1;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] c_ERR_DROP    = 2'd3;

    // Reject out-of-range timeout settings at elaboration.
    generate
        if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
            $error("pixel_sequencer: TIMEOUT_CYC must be within 2..65535");
        end
    endgenerate

    logic [3:0]           r_state;
    logic [7:0]           r_res_r;
    logic [7:0]           r_res_g;
    logic [7:0]           r_res_b;
    logic [PIX_CNT_W-1:0] r_frame_len;

    logic                 w_capture_state;
    logic                 w_get_state;
    logic                 w_rx_err;
    logic                 w_drop;
    logic                 w_timeout;
    logic [PIX_CNT_W-1:0] w_pix_inc;

    assign w_get_state     = (r_state == c_ST_GET_G) || (r_state == c_ST_GET_B);
    assign w_capture_state = (r_state == c_ST_IDLE) || w_get_state;
    assign w_rx_err        = data_ready && rx_error && w_capture_state;
    assign w_drop          = data_ready && !w_capture_state;
    assign w_pix_inc       = pixel_count + PIX_CNT_W'(1);

`ifdef PIXSEQ_TIMEOUT_EN
    // Counter value k means k full idle cycles have elapsed since the last
    // byte; expiry fires when the next increment would reach TIMEOUT_CYC-1.
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYC - 2);

    logic [15:0] r_to_cnt;

    assign w_timeout = w_get_state && !data_ready && (r_to_cnt == c_TO_LAST);

    // Inter-byte idle counter, restarted by every received byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= 16'd0;
        end else if (data_ready || !w_get_state) begin
            r_to_cnt <= 16'd0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Main sequencer: state, captured pixel, results, counters and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_res_r     <= 8'd0;
            r_res_g     <= 8'd0;
            r_res_b     <= 8'd0;
            r_frame_len <= '0;
            pix_r       <= 8'd0;
            pix_g       <= 8'd0;
            pix_b       <= 8'd0;
            core_mode   <= 2'd0;
            core_start  <= 1'b0;
            tx_data     <= 8'd0;
            tx_start    <= 1'b0;
            pixel_count <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            core_start <= 1'b0;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;

            // Single error pulse per cycle, rx_error outranking timeout and drop.
            if (w_rx_err) begin
                err      <= 1'b1;
                err_code <= c_ERR_RX;
            end else if (w_timeout) begin
                err      <= 1'b1;
                err_code <= c_ERR_TIMEOUT;
            end else if (w_drop) begin
                err      <= 1'b1;
                err_code <= c_ERR_DROP;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (data_ready && !rx_error) begin
                        pix_r   <= rx_data;
                        r_state <= c_ST_GET_G;
                    end
                end

                c_ST_GET_G: begin
                    if (data_ready) begin
                        if (rx_error) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            pix_g   <= rx_data;
                            r_state <= c_ST_GET_B;
                        end
                    end else if (w_timeout) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                c_ST_GET_B: begin
                    if (data_ready) begin
                        if (rx_error) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            // Decide here so core_start and core_mode are
                            // already registered during the START cycle.
                            pix_b      <= rx_data;
                            core_mode  <= mode;
                            core_start <= (mode != 2'd0);
                            if (pixel_count == '0) begin
                                r_frame_len <= frame_len;
                            end
                            r_state <= c_ST_START;
                        end
                    end else if (w_timeout) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                c_ST_START: begin
                    if (core_mode != 2'd0) begin
                        r_state <= c_ST_WAIT_CORE;
                    end else begin
                        r_res_r <= pix_r;
                        r_res_g <= pix_g;
                        r_res_b <= pix_b;
                        r_state <= c_ST_TX_R;
                    end
                end

                c_ST_WAIT_CORE: begin
                    if (core_done) begin
                        r_res_r <= core_r;
                        r_res_g <= core_g;
                        r_res_b <= core_b;
                        r_state <= c_ST_TX_R;
                    end
                end

                c_ST_TX_R: begin
                    if (!tx_busy) begin
                        tx_data  <= r_res_r;
                        tx_start <= 1'b1;
                        r_state  <= c_ST_TX_R_GRD;
                    end
                end

                c_ST_TX_R_GRD: r_state <= c_ST_TX_G;

                c_ST_TX_G: begin
                    if (!tx_busy) begin
                        tx_data  <= r_res_g;
                        tx_start <= 1'b1;
                        r_state  <= c_ST_TX_G_GRD;
                    end
                end

                c_ST_TX_G_GRD: r_state <= c_ST_TX_B;

                c_ST_TX_B: begin
                    if (!tx_busy) begin
                        tx_data  <= r_res_b;
                        tx_start <= 1'b1;
                        r_state  <= c_ST_TX_B_GRD;
                        if ((r_frame_len != '0) && (w_pix_inc == r_frame_len)) begin
                            pixel_count <= '0;
                            frame_done  <= 1'b1;
                        end else begin
                            pixel_count <= w_pix_inc;
                        end
                    end
                end

                c_ST_TX_B_GRD: r_state <= c_ST_IDLE;

                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_sequencer
// Description : Scoreboard bench for pixel_sequencer. Directed pixels push
//               expected core launches, transmit bytes and error codes into
//               queues; a negedge monitor pops and compares on each pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_sequencer;

    localparam int PIX_CNT_W   = 16;
    localparam int TIMEOUT_CYC = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [7:0]           rx_data = 8'd0;
    logic                 data_ready = 1'b0;
    logic                 rx_error = 1'b0;
    logic [1:0]           mode = 2'd0;
    logic [PIX_CNT_W-1:0] frame_len = '0;
    logic                 core_done = 1'b0;
    logic [7:0]           core_r = 8'd0;
    logic [7:0]           core_g = 8'd0;
    logic [7:0]           core_b = 8'd0;
    logic                 tx_busy = 1'b0;
    logic [7:0]           pix_r;
    logic [7:0]           pix_g;
    logic [7:0]           pix_b;
    logic [1:0]           core_mode;
    logic                 core_start;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic [PIX_CNT_W-1:0] pixel_count;
    logic                 frame_done;
    logic                 err;
    logic [1:0]           err_code;

    pixel_sequencer #(
        .PIX_CNT_W   (PIX_CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .data_ready  (data_ready),
        .rx_error    (rx_error),
        .mode        (mode),
        .frame_len   (frame_len),
        .core_done   (core_done),
        .core_r      (core_r),
        .core_g      (core_g),
        .core_b      (core_b),
        .tx_busy     (tx_busy),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .core_mode   (core_mode),
        .core_start  (core_start),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .pixel_count (pixel_count),
        .frame_done  (frame_done),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    // Expected events: core launch {mode,r,g,b}, tx {byte,pixel_count,frame_done}, err code.
    logic [25:0] q_core[$];
    logic [24:0] q_tx[$];
    logic [1:0]  q_err[$];

    int n_vec = 0;
    int n_err = 0;
    logic busy_en = 1'b0;

    // Monitor: every output pulse is matched against the head of its queue.
    initial begin
        logic prev_busy;
        logic [25:0] exp_c;
        logic [24:0] exp_t;
        logic [1:0]  exp_e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                n_vec++;
                if (q_core.size() == 0) begin
                    n_err++;
                    $display("FAIL core_start_unexpected: got mode=%0d pix=%h/%h/%h, want no launch",
                             core_mode, pix_r, pix_g, pix_b);
                end else begin
                    exp_c = q_core.pop_front();
                    if ({core_mode, pix_r, pix_g, pix_b} !== exp_c) begin
                        n_err++;
                        $display("FAIL core_launch: got %h want %h", {core_mode, pix_r, pix_g, pix_b}, exp_c);
                    end
                end
            end
            if (tx_start) begin
                n_vec++;
                if (q_tx.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_unexpected: got byte %h, want no tx_start", tx_data);
                end else begin
                    exp_t = q_tx.pop_front();
                    if ({tx_data, pixel_count, frame_done} !== exp_t) begin
                        n_err++;
                        $display("FAIL tx_byte: got data=%h cnt=%0d fd=%b want data=%h cnt=%0d fd=%b",
                                 tx_data, pixel_count, frame_done, exp_t[24:17], exp_t[16:1], exp_t[0]);
                    end
                end
                n_vec++;
                if (prev_busy) begin
                    n_err++;
                    $display("FAIL tx_while_busy: got tx_start after tx_busy=1, want tx_busy=0");
                end
            end else if (frame_done) begin
                n_vec++;
                n_err++;
                $display("FAIL frame_done_stray: got frame_done=1 without tx_start, want 0");
            end
            if (err) begin
                n_vec++;
                if (q_err.size() == 0) begin
                    n_err++;
                    $display("FAIL err_unexpected: got err code %0d, want no err", err_code);
                end else begin
                    exp_e = q_err.pop_front();
                    if (err_code !== exp_e) begin
                        n_err++;
                        $display("FAIL err_code: got %0d want %0d", err_code, exp_e);
                    end
                end
            end
            prev_busy = tx_busy;
        end
    end

    // Transmitter model: busy the cycle after each tx_start, for 20 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (busy_en && tx_start) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (20) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Safety net in case a wait is never satisfied.
    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_all_zero(input string name);
        n_vec++;
        if ({pix_r, pix_g, pix_b, core_mode, core_start, tx_data, tx_start,
             pixel_count, frame_done, err, err_code} !== '0) begin
            n_err++;
            $display("FAIL %s: got pix=%h/%h/%h mode=%0d cs=%b tx=%h ts=%b cnt=%0d fd=%b err=%b code=%0d, want all 0",
                     name, pix_r, pix_g, pix_b, core_mode, core_start, tx_data, tx_start,
                     pixel_count, frame_done, err, err_code);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; tasks start and end there.
    task automatic send_byte(input logic [7:0] b, input logic e);
        rx_data    = b;
        rx_error   = e;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        rx_error   = 1'b0;
    endtask

    task automatic wait_core_start();
        int k;
        k = 0;
        while (!core_start && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (!core_start) begin
            n_err++;
            $display("FAIL core_start_wait: got none in 20 cycles, want one");
        end
    endtask

    task automatic pulse_core(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        core_r    = r;
        core_g    = g;
        core_b    = b;
        core_done = 1'b1;
        @(posedge clk);
        #1 core_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((q_tx.size() != 0 || q_core.size() != 0 || q_err.size() != 0) && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (q_tx.size() != 0 || q_core.size() != 0 || q_err.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d tx/%0d core/%0d err pending, want 0",
                     name, q_tx.size(), q_core.size(), q_err.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T1: mode 3 through the core; mode changes after B must not matter
        mode = 2'd3;
        q_core.push_back({2'd3, 8'h10, 8'h20, 8'h30});
        q_tx.push_back({8'hAA, 16'd0, 1'b0});
        q_tx.push_back({8'hBB, 16'd0, 1'b0});
        q_tx.push_back({8'hCC, 16'd1, 1'b0});
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        mode = 2'd0;
        wait_core_start();
        repeat (5) @(posedge clk);
        #1;
        pulse_core(8'hAA, 8'hBB, 8'hCC);
        wait_drain("t1");

        // T2: passthrough, no core launch
        mode = 2'd0;
        q_tx.push_back({8'h10, 16'd1, 1'b0});
        q_tx.push_back({8'h20, 16'd1, 1'b0});
        q_tx.push_back({8'h30, 16'd2, 1'b0});
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        wait_drain("t2");

        // T3: rx_error on G discards the pixel; next pixel is clean
        mode = 2'd2;
        q_err.push_back(2'd1);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        q_core.push_back({2'd2, 8'h01, 8'h02, 8'h03});
        q_tx.push_back({8'h40, 16'd2, 1'b0});
        q_tx.push_back({8'h41, 16'd2, 1'b0});
        q_tx.push_back({8'h42, 16'd3, 1'b0});
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        wait_core_start();
        repeat (2) @(posedge clk);
        #1;
        pulse_core(8'h40, 8'h41, 8'h42);
        wait_drain("t3");

`ifdef PIXSEQ_TIMEOUT_EN
        // T4: R byte then silence; timeout 15 edges after the accepting edge
        begin
            int n;
            q_err.push_back(2'd2);
            send_byte(8'h77, 1'b0);
            n = 0;
            while (!err && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            n_vec++;
            if (n != TIMEOUT_CYC - 1) begin
                n_err++;
                $display("FAIL timeout_latency: got %0d cycles want %0d", n, TIMEOUT_CYC - 1);
            end
            wait_drain("t4");
        end
`endif

        // T6: reset during WAIT_CORE; late core_done ignored; fresh pixel follows
        mode = 2'd1;
        q_core.push_back({2'd1, 8'h07, 8'h08, 8'h09});
        send_byte(8'h07, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h09, 1'b0);
        wait_core_start();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_core(8'hE1, 8'hE2, 8'hE3);
        repeat (10) @(posedge clk);
        #1;
        mode = 2'd0;
        q_tx.push_back({8'h61, 16'd0, 1'b0});
        q_tx.push_back({8'h62, 16'd0, 1'b0});
        q_tx.push_back({8'h63, 16'd1, 1'b0});
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b0);
        wait_drain("t6");

        // T5: frame_len=2 with a slow transmitter
        do_reset();
        busy_en   = 1'b1;
        frame_len = 16'd2;
        mode      = 2'd0;
        q_tx.push_back({8'h71, 16'd0, 1'b0});
        q_tx.push_back({8'h72, 16'd0, 1'b0});
        q_tx.push_back({8'h73, 16'd1, 1'b0});
        send_byte(8'h71, 1'b0);
        send_byte(8'h72, 1'b0);
        send_byte(8'h73, 1'b0);
        wait_drain("t5a");
        repeat (25) @(posedge clk);
        #1;
        q_tx.push_back({8'h81, 16'd1, 1'b0});
        q_tx.push_back({8'h82, 16'd1, 1'b0});
        q_tx.push_back({8'h83, 16'd0, 1'b1});
        send_byte(8'h81, 1'b0);
        send_byte(8'h82, 1'b0);
        send_byte(8'h83, 1'b0);
        wait_drain("t5b");
        repeat (25) @(posedge clk);
        #1;
        n_vec++;
        if (pixel_count !== 16'd0) begin
            n_err++;
            $display("FAIL frame_count_clear: got %0d want 0", pixel_count);
        end
        busy_en = 1'b0;

        // T7: byte arriving during WAIT_CORE is dropped, sequencing continues
        mode = 2'd1;
        q_core.push_back({2'd1, 8'h01, 8'h02, 8'h03});
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        wait_core_start();
        @(posedge clk);
        #1;
        q_err.push_back(2'd3);
        send_byte(8'h99, 1'b0);
        q_tx.push_back({8'h11, 16'd0, 1'b0});
        q_tx.push_back({8'h22, 16'd0, 1'b0});
        q_tx.push_back({8'h33, 16'd1, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        pulse_core(8'h11, 8'h22, 8'h33);
        wait_drain("t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
